// File: rtl/dff_pipe.sv
// Elastic register pipeline: STAGES valid/data stages with a combinational ready
// chain, so bubbles are squeezed out while the output end is stalled.
module dff_pipe #(
    parameter int N      = 32,
    parameter int STAGES = 4
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            en,
    input  logic                            flush,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic [N-1:0]                    d,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [N-1:0]                    q,
    output logic [N-1:0]                    qn,
    output logic [$clog2(STAGES+1)-1:0]     count
);

    localparam int CW = $clog2(STAGES + 1);

    logic [STAGES-1:0] v_q, v_d;
    logic [N-1:0]      data_q [STAGES];
    logic [N-1:0]      data_d [STAGES];
    logic [STAGES-1:0] rdy;
    logic [CW-1:0]     count_c;

    // Ready ripples from the output end toward the input end.
    always_comb begin
        logic r;
        int unsigned k;
        r   = out_ready;
        rdy = '0;
        for (int unsigned i = 0; i < STAGES; i++) begin
            k      = STAGES - 1 - i;
            r      = !v_q[k] || r;
            rdy[k] = r;
        end
    end

    always_comb begin
        v_d = v_q;
        for (int unsigned k = 0; k < STAGES; k++) begin
            data_d[k] = data_q[k];
        end
        if (flush) begin
            v_d = '0;
        end else if (en) begin
            if (rdy[0]) begin
                v_d[0] = in_valid;
                if (in_valid) data_d[0] = d;
            end
            for (int unsigned k = 1; k < STAGES; k++) begin
                if (rdy[k]) begin
                    v_d[k] = v_q[k-1];
                    if (v_q[k-1]) data_d[k] = data_q[k-1];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v_q <= '0;
            for (int unsigned k = 0; k < STAGES; k++) begin
                data_q[k] <= '0;
            end
        end else begin
            v_q <= v_d;
            for (int unsigned k = 0; k < STAGES; k++) begin
                data_q[k] <= data_d[k];
            end
        end
    end

    always_comb begin
        count_c = '0;
        for (int unsigned k = 0; k < STAGES; k++) begin
            count_c = count_c + CW'(v_q[k]);
        end
    end

    // rst gating keeps the handshake quiet while reset is held.
    assign in_ready  = en && rdy[0] && !flush && !rst;
    assign out_valid = en && v_q[STAGES-1] && !flush && !rst;
    assign q         = data_q[STAGES-1];
    assign qn        = ~data_q[STAGES-1];
    assign count     = count_c;

endmodule

// File: tb/tb_dff_pipe.sv
// Directed bench for dff_pipe: vector table for latency/throughput, then
// hand sequences for backpressure, stall, flush, bubble collapse and reset.
module tb_dff_pipe;

    logic        clk = 1'b0;
    logic        rst, en, flush, in_valid, out_ready;
    logic [31:0] d;
    logic        in_ready, out_valid;
    logic [31:0] q, qn;
    logic [2:0]  count;

    logic        iv1, or1;
    logic [7:0]  d1;
    logic        ir1, ov1;
    logic [7:0]  q1, qn1;
    logic [0:0]  cnt1;

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    dff_pipe #(.N(32), .STAGES(4)) dut (
        .clk(clk), .rst(rst), .en(en), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .d(d),
        .out_valid(out_valid), .out_ready(out_ready),
        .q(q), .qn(qn), .count(count)
    );

    dff_pipe #(.N(8), .STAGES(1)) dut1 (
        .clk(clk), .rst(rst), .en(en), .flush(flush),
        .in_valid(iv1), .in_ready(ir1), .d(d1),
        .out_valid(ov1), .out_ready(or1),
        .q(q1), .qn(qn1), .count(cnt1)
    );

    typedef struct {
        logic        en, flush, iv, ordy;
        logic [31:0] d;
        logic        ov, ir;
        logic [31:0] q;
        logic [2:0]  cnt;
    } vec_t;

    vec_t tbl [$];

    task automatic add(input logic e, input logic fl, input logic iv, input logic o,
                       input logic [31:0] dd, input logic ov, input logic ir,
                       input logic [31:0] qq, input logic [2:0] c);
        vec_t v;
        v.en = e; v.flush = fl; v.iv = iv; v.ordy = o; v.d = dd;
        v.ov = ov; v.ir = ir; v.q = qq; v.cnt = c;
        tbl.push_back(v);
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic e, input logic fl, input logic iv, input logic o,
                         input logic [31:0] dd);
        @(negedge clk);
        en = e; flush = fl; in_valid = iv; out_ready = o; d = dd;
    endtask

    initial begin
        rst = 1'b0; en = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; d = '0;
        iv1 = 1'b0; or1 = 1'b0; d1 = '0;

        // Expected values describe the state just before the edge that follows.
        add(1'b1, 1'b0, 1'b1, 1'b1, 32'h00A97C01, 1'b0, 1'b1, 32'h0, 3'd0);
        add(1'b1, 1'b0, 1'b0, 1'b1, 32'h0, 1'b0, 1'b1, 32'h0, 3'd1);
        add(1'b1, 1'b0, 1'b0, 1'b1, 32'h0, 1'b0, 1'b1, 32'h0, 3'd1);
        add(1'b1, 1'b0, 1'b0, 1'b1, 32'h0, 1'b0, 1'b1, 32'h0, 3'd1);
        add(1'b1, 1'b0, 1'b0, 1'b1, 32'h0, 1'b1, 1'b1, 32'h00A97C01, 3'd1);
        add(1'b1, 1'b0, 1'b0, 1'b1, 32'h0, 1'b0, 1'b1, 32'h00A97C01, 3'd0);
        add(1'b1, 1'b0, 1'b1, 1'b1, 32'h11, 1'b0, 1'b1, 32'h00A97C01, 3'd0);
        add(1'b1, 1'b0, 1'b1, 1'b1, 32'h22, 1'b0, 1'b1, 32'h00A97C01, 3'd1);
        add(1'b1, 1'b0, 1'b1, 1'b1, 32'h33, 1'b0, 1'b1, 32'h00A97C01, 3'd2);
        add(1'b1, 1'b0, 1'b1, 1'b1, 32'h44, 1'b0, 1'b1, 32'h00A97C01, 3'd3);
        add(1'b1, 1'b0, 1'b1, 1'b1, 32'h55, 1'b1, 1'b1, 32'h11, 3'd4);
        add(1'b1, 1'b0, 1'b0, 1'b1, 32'h0, 1'b1, 1'b1, 32'h22, 3'd4);
        add(1'b1, 1'b0, 1'b0, 1'b1, 32'h0, 1'b1, 1'b1, 32'h33, 3'd3);
        add(1'b1, 1'b0, 1'b0, 1'b1, 32'h0, 1'b1, 1'b1, 32'h44, 3'd2);
        add(1'b1, 1'b0, 1'b0, 1'b1, 32'h0, 1'b1, 1'b1, 32'h55, 3'd1);
        add(1'b1, 1'b0, 1'b0, 1'b1, 32'h0, 1'b0, 1'b1, 32'h55, 3'd0);

        // Asynchronous reset between edges
        #2 rst = 1'b1;
        #1;
        chk("rst q", q, 32'h0);
        chk("rst qn", qn, 32'hFFFFFFFF);
        chk("rst count", 32'(count), 32'd0);
        chk("rst out_valid", 32'(out_valid), 32'd0);
        chk("rst in_ready", 32'(in_ready), 32'd0);
        chk("rst q1", 32'(q1), 32'h0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        for (int unsigned i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].en, tbl[i].flush, tbl[i].iv, tbl[i].ordy, tbl[i].d);
            #1;
            chk($sformatf("vec%0d out_valid", i), 32'(out_valid), 32'(tbl[i].ov));
            chk($sformatf("vec%0d in_ready", i), 32'(in_ready), 32'(tbl[i].ir));
            chk($sformatf("vec%0d q", i), q, tbl[i].q);
            chk($sformatf("vec%0d qn", i), qn, ~tbl[i].q);
            chk($sformatf("vec%0d count", i), 32'(count), 32'(tbl[i].cnt));
        end

        // Backpressure: 4 words fill the pipe, the 5th waits upstream
        for (int unsigned w = 1; w <= 4; w++) begin
            drive(1'b1, 1'b0, 1'b1, 1'b0, 32'(w));
            #1 chk($sformatf("bp push%0d in_ready", w), 32'(in_ready), 32'd1);
        end
        for (int unsigned r = 0; r < 2; r++) begin
            drive(1'b1, 1'b0, 1'b1, 1'b0, 32'd5);
            #1;
            chk("bp full in_ready", 32'(in_ready), 32'd0);
            chk("bp full count", 32'(count), 32'd4);
            chk("bp full q", q, 32'd1);
        end
        drive(1'b1, 1'b0, 1'b1, 1'b1, 32'd5);
        #1;
        chk("bp release in_ready", 32'(in_ready), 32'd1);
        chk("bp release out_valid", 32'(out_valid), 32'd1);
        chk("bp out1", q, 32'd1);
        for (int unsigned w = 2; w <= 5; w++) begin
            drive(1'b1, 1'b0, 1'b0, 1'b1, 32'h0);
            #1;
            chk($sformatf("bp out%0d valid", w), 32'(out_valid), 32'd1);
            chk($sformatf("bp out%0d q", w), q, 32'(w));
        end
        drive(1'b1, 1'b0, 1'b0, 1'b1, 32'h0);
        #1 chk("bp drained count", 32'(count), 32'd0);

        // Stall with full pipe
        for (int unsigned w = 0; w < 4; w++) drive(1'b1, 1'b0, 1'b1, 1'b0, 32'hA1 + 32'(w));
        for (int unsigned r = 0; r < 3; r++) begin
            drive(1'b0, 1'b0, 1'b1, 1'b1, 32'hEE);
            #1;
            chk("stall out_valid", 32'(out_valid), 32'd0);
            chk("stall in_ready", 32'(in_ready), 32'd0);
            chk("stall count", 32'(count), 32'd4);
            chk("stall q", q, 32'hA1);
        end
        for (int unsigned w = 0; w < 4; w++) begin
            drive(1'b1, 1'b0, 1'b0, 1'b1, 32'h0);
            #1;
            chk("resume out_valid", 32'(out_valid), 32'd1);
            chk("resume q", q, 32'hA1 + 32'(w));
        end
        drive(1'b1, 1'b0, 1'b0, 1'b1, 32'h0);
        #1 chk("resume drained count", 32'(count), 32'd0);

        // Flush with full pipe and a word presented
        for (int unsigned w = 0; w < 4; w++) drive(1'b1, 1'b0, 1'b1, 1'b0, 32'hB1 + 32'(w));
        drive(1'b1, 1'b1, 1'b1, 1'b1, 32'hCC);
        #1;
        chk("flush in_ready", 32'(in_ready), 32'd0);
        chk("flush out_valid", 32'(out_valid), 32'd0);
        drive(1'b1, 1'b0, 1'b0, 1'b1, 32'h0);
        #1;
        chk("post-flush count", 32'(count), 32'd0);
        chk("post-flush out_valid", 32'(out_valid), 32'd0);
        chk("post-flush q", q, 32'hB1);
        repeat (4) drive(1'b1, 1'b0, 1'b0, 1'b1, 32'h0);
        #1 chk("post-flush idle count", 32'(count), 32'd0);

        // Bubble collapse: words at stages 0 and 3, output stalled
        drive(1'b1, 1'b0, 1'b1, 1'b0, 32'hD1);
        repeat (3) drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        drive(1'b1, 1'b0, 1'b1, 1'b0, 32'hD2);
        for (int unsigned r = 0; r < 3; r++) begin
            drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
            #1;
            chk("bubble count", 32'(count), 32'd2);
            chk("bubble q", q, 32'hD1);
        end
        drive(1'b1, 1'b0, 1'b0, 1'b1, 32'h0);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        #1;
        chk("bubble next valid", 32'(out_valid), 32'd1);
        chk("bubble next q", q, 32'hD2);
        chk("bubble next count", 32'(count), 32'd1);

        // Reset mid-operation, then accept on the first edge after release
        @(negedge clk);
        #3 rst = 1'b1;
        #1;
        chk("midrst count", 32'(count), 32'd0);
        chk("midrst q", q, 32'h0);
        chk("midrst qn", qn, 32'hFFFFFFFF);
        chk("midrst out_valid", 32'(out_valid), 32'd0);
        chk("midrst in_ready", 32'(in_ready), 32'd0);
        @(negedge clk);
        rst = 1'b0; en = 1'b1; in_valid = 1'b1; d = 32'h77; out_ready = 1'b0;
        #1 chk("post-rst in_ready", 32'(in_ready), 32'd1);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        #1 chk("post-rst count", 32'(count), 32'd1);

        // Single-stage instance
        @(negedge clk);
        iv1 = 1'b1; d1 = 8'h5A; or1 = 1'b0;
        #1 chk("s1 empty in_ready", 32'(ir1), 32'd1);
        @(negedge clk);
        d1 = 8'hA5;
        #1;
        chk("s1 full out_valid", 32'(ov1), 32'd1);
        chk("s1 full q", 32'(q1), 32'h5A);
        chk("s1 full qn", 32'(qn1), 32'hA5);
        chk("s1 full in_ready", 32'(ir1), 32'd0);
        @(negedge clk);
        or1 = 1'b1;
        #1;
        chk("s1 held q", 32'(q1), 32'h5A);
        chk("s1 pass in_ready", 32'(ir1), 32'd1);
        @(negedge clk);
        iv1 = 1'b0;
        #1;
        chk("s1 second q", 32'(q1), 32'hA5);
        chk("s1 second count", 32'(cnt1), 32'd1);
        @(negedge clk);
        #1;
        chk("s1 empty out_valid", 32'(ov1), 32'd0);
        chk("s1 stale q", 32'(q1), 32'hA5);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
